// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler
//
// Time-multiplexed 39-tap FIR controller. A single signed DATA_W x DATA_W
// multiply-accumulate is stepped over every tap once per accepted sample.
// The block owns the circular sample history, the writable coefficient
// store, the input/output handshakes and the tap schedule.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_valid   sample offered by the source
//   in_data    signed sample (NULL_CODE is stored as zero)
//   in_ready   scheduler takes a sample this cycle
//   coef_we    coefficient write strobe
//   coef_addr  tap index of the coefficient write
//   coef_data  signed coefficient value
//   coef_err   one-cycle pulse after a rejected coefficient write
//   flush      clears sample history (IDLE only)
//   busy       MAC sequence in progress
//   y_valid    one-cycle pulse when y_out has been updated
//   y_out      filter result, low OUT_W bits of the accumulator
//
// Timing: a sample accepted at edge T sweeps taps on edges T+1..T+N_TAPS,
// the DONE state is left at edge T+N_TAPS+1, which loads y_out and raises
// y_valid. The next sample can be accepted at edge T+N_TAPS+2.

module fir_mac_scheduler #(
  parameter int                N_TAPS    = 39,
  parameter int                DATA_W    = 16,
  parameter int                ACC_W     = 40,
  parameter int                OUT_W     = 32,
  parameter logic [DATA_W-1:0] NULL_CODE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [5:0]        coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_err,
  input  logic              flush,
  output logic              busy,
  output logic              y_valid,
  output logic [OUT_W-1:0]  y_out
);

  localparam logic [5:0] TAPS6  = 6'(N_TAPS);
  localparam logic [5:0] N_LAST = 6'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  sample_mem [N_TAPS];
  logic signed [DATA_W-1:0]  coef_mem   [N_TAPS];
  logic [5:0]                wr_ptr;
  logic [5:0]                base;
  logic [5:0]                tap;
  logic [5:0]                rd_idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]   product_ext;
  logic                      coef_ok;
  logic                      unused_acc_hi;

  // Accept only in IDLE, and never on a flush cycle (flush has priority).
  assign in_ready = !rst && (state == IDLE) && !flush;
  assign busy     = (state == MAC);
  assign coef_ok  = (state == IDLE) && (coef_addr < TAPS6);

  // The accumulator guard bits above OUT_W are intentionally dropped at the
  // output (wrap, no saturation).
  assign unused_acc_hi = ^acc[ACC_W-1:OUT_W];

  // Tap k reads the sample k positions older than the newest one,
  // walking backwards through the circular history.
  always_comb begin
    rd_idx = base - tap;
    if (base < tap) begin
      rd_idx = base + TAPS6 - tap;
    end
  end

  // Full-precision signed product, sign-extended into the accumulator.
  always_comb begin
    product     = sample_mem[rd_idx] * coef_mem[tap];
    product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
  end

  // Scheduler FSM with the sample/coefficient stores and registered outputs.
  // A coefficient write and a sample accept on the same IDLE edge both land,
  // so the computation that starts there already sees the new coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      base     <= '0;
      tap      <= '0;
      acc      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      coef_err <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        sample_mem[i] <= '0;
        coef_mem[i]   <= '0;
      end
    end else begin
      y_valid  <= 1'b0;
      coef_err <= coef_we && !coef_ok;
      if (coef_we && coef_ok) begin
        coef_mem[coef_addr] <= coef_data;
      end
      case (state)
        IDLE: begin
          if (flush) begin
            wr_ptr <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
              sample_mem[i] <= '0;
            end
          end else if (in_valid) begin
            sample_mem[wr_ptr] <= (in_data == NULL_CODE) ? '0 : in_data;
            base   <= wr_ptr;
            wr_ptr <= (wr_ptr == N_LAST) ? '0 : wr_ptr + 6'd1;
            acc    <= '0;
            tap    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + product_ext;
          if (tap == N_LAST) begin
            state <= DONE;
          end else begin
            tap <= tap + 6'd1;
          end
        end
        DONE: begin
          y_out   <= acc[OUT_W-1:0];
          y_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed testbench for fir_mac_scheduler. Each scenario task drives its
// own stimulus and compares against hand-computed values.
module tb_fir_mac_scheduler;

  localparam int N_TAPS = 39;
  localparam int LAT    = N_TAPS + 1;  // edges from accept edge to y_valid visible

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_err;
  logic        flush;
  logic        busy;
  logic        y_valid;
  logic [31:0] y_out;

  int checks = 0;
  int errors = 0;

  fir_mac_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .flush     (flush),
    .busy      (busy),
    .y_valid   (y_valid),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all inputs change 1 time unit after a rising edge,
  // and outputs are sampled at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_y(output logic [31:0] y, output int lat);
    y   = '0;
    lat = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      step();
      if (y_valid) begin
        y   = y_out;
        lat = n;
      end
    end
  endtask

  task automatic run_sample(input logic [15:0] s, output logic [31:0] y, output int lat);
    in_data  = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_y(y, lat);
  endtask

  task automatic write_coef(input logic [5:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    step();
    coef_we   = 1'b0;
  endtask

  // mode 0: coef[k]=k+1, mode 1: all 16'h0100, mode 2: coef[0]=1, rest 0
  task automatic load_coefs(input int mode, output int err_count);
    logic [15:0] d;
    err_count = 0;
    for (int k = 0; k < N_TAPS; k++) begin
      case (mode)
        0: d = 16'(k + 1);
        1: d = 16'h0100;
        default: d = (k == 0) ? 16'h0001 : 16'h0000;
      endcase
      write_coef(6'(k), d);
      if (coef_err) err_count++;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (y_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_y_out got %h want 0", y_out); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_valid got %b want 0", y_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (coef_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_coef_err got %b want 0", coef_err); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_impulse();
    int          e;
    int          lat;
    logic [31:0] y;
    logic [31:0] expv;
    load_coefs(0, e);
    checks++; if (e != 0) begin errors++; $display("[TB] FAIL impulse_coef_load got %0d errs want 0", e); end
    for (int i = 0; i <= N_TAPS; i++) begin
      run_sample((i == 0) ? 16'h0001 : 16'h0000, y, lat);
      expv = (i < N_TAPS) ? 32'(i + 1) : 32'h0;
      checks++; if (y !== expv) begin errors++; $display("[TB] FAIL impulse_y[%0d] got %h want %h", i, y, expv); end
      checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL impulse_latency[%0d] got %0d want %0d", i, lat, LAT); end
    end
    in_data  = 16'h0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mac_busy got %b want 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mac_in_ready got %b want 0", in_ready); end
    wait_y(y, lat);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy got %b want 0", busy); end
    checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL impulse_tail got %h want 0", y); end
  endtask

  task automatic test_dc_gain();
    int          e;
    int          lat;
    logic [31:0] y;
    logic [31:0] expv;
    do_flush();
    load_coefs(1, e);
    for (int k = 1; k <= N_TAPS; k++) begin
      run_sample(16'h0010, y, lat);
      expv = 32'(k) * 32'h1000;
      checks++; if (y !== expv) begin errors++; $display("[TB] FAIL dc_y[%0d] got %h want %h", k, y, expv); end
    end
    checks++; if (y !== 32'h00027000) begin errors++; $display("[TB] FAIL dc_final got %h want 00027000", y); end
  endtask

  task automatic test_sign_null();
    int          e;
    int          lat;
    logic [31:0] y;
    do_flush();
    load_coefs(2, e);
    run_sample(16'h8000, y, lat);
    checks++; if (y !== 32'hFFFF8000) begin errors++; $display("[TB] FAIL sign_y got %h want FFFF8000", y); end
    run_sample(16'hFFFF, y, lat);
    checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL null_y got %h want 0", y); end
  endtask

  task automatic test_coef_reject();
    int          lat;
    logic [31:0] y;
    do_flush();
    run_sample(16'h0005, y, lat);
    checks++; if (y !== 32'h5) begin errors++; $display("[TB] FAIL reject_baseline got %h want 5", y); end
    // Write while busy
    in_data  = 16'h0007;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    write_coef(6'd0, 16'd100);
    checks++; if (coef_err !== 1'b1) begin errors++; $display("[TB] FAIL busy_coef_err got %b want 1", coef_err); end
    step();
    checks++; if (coef_err !== 1'b0) begin errors++; $display("[TB] FAIL coef_err_pulse got %b want 0", coef_err); end
    wait_y(y, lat);
    checks++; if (y !== 32'h7) begin errors++; $display("[TB] FAIL busy_write_ignored got %h want 7", y); end
    // Out-of-range address in IDLE
    write_coef(6'd39, 16'd100);
    checks++; if (coef_err !== 1'b1) begin errors++; $display("[TB] FAIL addr39_coef_err got %b want 1", coef_err); end
    run_sample(16'h0009, y, lat);
    checks++; if (y !== 32'h9) begin errors++; $display("[TB] FAIL addr39_no_change got %h want 9", y); end
    // Coefficient write on the same edge as a sample accept
    in_data   = 16'h0003;
    in_valid  = 1'b1;
    coef_we   = 1'b1;
    coef_addr = 6'd0;
    coef_data = 16'h0002;
    step();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    checks++; if (coef_err !== 1'b0) begin errors++; $display("[TB] FAIL simul_coef_err got %b want 0", coef_err); end
    wait_y(y, lat);
    checks++; if (y !== 32'h6) begin errors++; $display("[TB] FAIL simul_new_coef got %h want 6", y); end
  endtask

  task automatic test_flush_wrap();
    int          e;
    int          lat;
    logic [31:0] y;
    load_coefs(0, e);
    do_flush();
    for (int j = 0; j < 45; j++) begin
      run_sample((j == 0) ? 16'h0001 : 16'h0000, y, lat);
      if (j == 38) begin
        checks++; if (y !== 32'd39) begin errors++; $display("[TB] FAIL wrap_last_tap got %h want 27", y); end
      end else if (j == 39 || j == 44) begin
        checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL wrap_overwrite[%0d] got %h want 0", j, y); end
      end
    end
    // Impulse after the write pointer has wrapped
    for (int j = 0; j < 3; j++) begin
      run_sample((j == 0) ? 16'h0001 : 16'h0000, y, lat);
      checks++; if (y !== 32'(j + 1)) begin errors++; $display("[TB] FAIL wrap_impulse[%0d] got %h want %h", j, y, 32'(j + 1)); end
    end
    // Flush beats a simultaneous sample
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0050;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept got %b want 0", busy); end
    run_sample(16'h0004, y, lat);
    checks++; if (y !== 32'h4) begin errors++; $display("[TB] FAIL post_flush got %h want 4", y); end
    // Flush during MAC is ignored
    in_data  = 16'h0002;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    wait_y(y, lat);
    checks++; if (y !== 32'd10) begin errors++; $display("[TB] FAIL mac_flush_y got %h want a", y); end
    run_sample(16'h0000, y, lat);
    checks++; if (y !== 32'd16) begin errors++; $display("[TB] FAIL mac_flush_kept got %h want 10", y); end
  endtask

  task automatic test_reset_mid_mac();
    int          e;
    int          lat;
    int          pulses;
    logic [31:0] y;
    in_data  = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    checks++; if (y_out !== 32'h0) begin errors++; $display("[TB] FAIL midrst_y_out got %h want 0", y_out); end
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    pulses = 0;
    repeat (60) begin
      step();
      if (y_valid) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL midrst_y_valid got %0d pulses want 0", pulses); end
    load_coefs(0, e);
    for (int j = 0; j < 3; j++) begin
      run_sample((j == 0) ? 16'h0001 : 16'h0000, y, lat);
      checks++; if (y !== 32'(j + 1)) begin errors++; $display("[TB] FAIL midrst_impulse[%0d] got %h want %h", j, y, 32'(j + 1)); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    flush     = 1'b0;
    test_reset();
    test_impulse();
    test_dc_gain();
    test_sign_null();
    test_coef_reject();
    test_flush_wrap();
    test_reset_mid_mac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
